// File: rtl/axi_byte_access.sv
// axi_byte_access: moves one byte per start between the sequencer and memory,
// as a single AR/R or AW/W/B transaction on a 64-bit AXI4-Lite-style master.
module axi_byte_access (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [7:0]  data_write,
  output logic        busy,
  output logic        done,
  output logic [7:0]  data_read,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic        arvalid,
  output logic        rready,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        wready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wvalid,
  output logic        bready,
  input  logic [1:0]  bresp,
  input  logic        bvalid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  lane_r;
  logic [2:0]  lane_s;
  logic        busy_s;
  logic        done_s;
  logic        arvalid_s;
  logic        rready_s;
  logic        awvalid_s;
  logic        wvalid_s;
  logic        bready_s;
  logic [31:0] araddr_s;
  logic [31:0] awaddr_s;
  logic [63:0] wdata_s;
  logic [7:0]  wstrb_s;
  logic [7:0]  data_read_s;
  logic        ar_hs_s;
  logic        r_hs_s;
  logic        b_hs_s;
  logic        aw_ok_s;
  logic        w_ok_s;
  logic        unused_s;

  assign ar_hs_s = arvalid & arready;
  assign r_hs_s  = rvalid & rready;
  assign b_hs_s  = bvalid & bready;
  // A write channel counts as finished once its valid has dropped or is handshaking now.
  assign aw_ok_s = ~awvalid | awready;
  assign w_ok_s  = ~wvalid | wready;
  // Response codes are deliberately ignored: error responses complete like OKAY.
  assign unused_s = ^{rresp, bresp};

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = write ? WR_REQ : RD_ADDR;
        end else begin
          state_s = IDLE;
        end
      end
      RD_ADDR: begin
        if (ar_hs_s) begin
          state_s = RD_DATA;
        end else begin
          state_s = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (r_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = RD_DATA;
        end
      end
      WR_REQ: begin
        if (aw_ok_s && w_ok_s) begin
          state_s = WR_RESP;
        end else begin
          state_s = WR_REQ;
        end
      end
      WR_RESP: begin
        if (b_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = WR_RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the current and next state.
  always_comb begin
    busy_s      = (state_s != IDLE);
    done_s      = ((state_r == RD_DATA) && r_hs_s) || ((state_r == WR_RESP) && b_hs_s);
    arvalid_s   = (state_s == RD_ADDR);
    rready_s    = (state_s == RD_DATA);
    bready_s    = (state_s == WR_RESP);
    awvalid_s   = 1'b0;
    wvalid_s    = 1'b0;
    lane_s      = lane_r;
    araddr_s    = araddr;
    awaddr_s    = awaddr;
    wdata_s     = wdata;
    wstrb_s     = wstrb;
    data_read_s = data_read;
    case (state_r)
      IDLE: begin
        if (start) begin
          lane_s = addr[2:0];
          if (write) begin
            awaddr_s  = {addr[31:3], 3'b000};
            wdata_s   = {8{data_write}};
            wstrb_s   = 8'b0000_0001 << addr[2:0];
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
          end else begin
            araddr_s = {addr[31:3], 3'b000};
          end
        end else begin
          lane_s = lane_r;
        end
      end
      RD_DATA: begin
        if (r_hs_s) begin
          data_read_s = rdata[{lane_r, 3'b000} +: 8];
        end else begin
          data_read_s = data_read;
        end
      end
      WR_REQ: begin
        // Each write valid drops on its own handshake; both clear on leaving WR_REQ.
        if (state_s == WR_REQ) begin
          awvalid_s = awvalid & ~awready;
          wvalid_s  = wvalid & ~wready;
        end else begin
          awvalid_s = 1'b0;
          wvalid_s  = 1'b0;
        end
      end
      default: begin
        lane_s = lane_r;
      end
    endcase
  end

  // Output and lane registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lane_r    <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      araddr    <= 32'd0;
      awaddr    <= 32'd0;
      wdata     <= 64'd0;
      wstrb     <= 8'd0;
      data_read <= 8'd0;
    end else begin
      lane_r    <= lane_s;
      busy      <= busy_s;
      done      <= done_s;
      arvalid   <= arvalid_s;
      rready    <= rready_s;
      awvalid   <= awvalid_s;
      wvalid    <= wvalid_s;
      bready    <= bready_s;
      araddr    <= araddr_s;
      awaddr    <= awaddr_s;
      wdata     <= wdata_s;
      wstrb     <= wstrb_s;
      data_read <= data_read_s;
    end
  end

endmodule

// File: tb/tb_axi_byte_access.sv
// Self-checking bench for axi_byte_access: a delay-configurable AXI slave backed by a
// word memory, checked against a byte-addressed reference memory and latency model.
module tb_axi_byte_access;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [7:0]  data_write = 8'd0;
  logic        busy, done;
  logic [7:0]  data_read;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic        arvalid, rready;
  logic [63:0] rdata = 64'd0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        awready = 1'b0;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        wready = 1'b0;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid, bready;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0;

  axi_byte_access dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .write(write), .addr(addr),
    .data_write(data_write), .busy(busy), .done(done), .data_read(data_read),
    .arready(arready), .araddr(araddr), .arvalid(arvalid),
    .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .awready(awready), .awaddr(awaddr), .awvalid(awvalid),
    .wready(wready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid),
    .bready(bready), .bresp(bresp), .bvalid(bvalid)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration and state.
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [1:0] resp_cfg = 2'b00;
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  bit r_pend = 0, aw_got = 0, w_got = 0, b_pend = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic [31:0] last_araddr = 32'd0, last_awaddr = 32'd0;
  logic [63:0] last_wdata = 64'd0;
  logic [7:0]  last_wstrb = 8'd0;
  logic [63:0] word_mem [int];
  logic [7:0]  ref_mem [logic [31:0]];

  function automatic logic [63:0] init_word(input int idx);
    logic [31:0] a, b;
    a = idx * 32'h9E37_79B1;
    b = ~idx * 32'h85EB_CA6B;
    return {a, b};
  endfunction

  function automatic logic [63:0] get_word(input int idx);
    if (word_mem.exists(idx)) return word_mem[idx];
    else return init_word(idx);
  endfunction

  // Reference model: flat byte memory with the same power-on contents.
  function automatic logic [7:0] model_byte(input logic [31:0] a);
    logic [63:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word(int'(a >> 3));
    return w[{a[2:0], 3'b000} +: 8];
  endfunction

  // AXI slave: decides readies/valids at each falling edge for the next rising edge.
  initial begin
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ar_wait = 0; aw_wait = 0; w_wait = 0;
        arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      end else begin
        if (r_pend && r_wait >= r_dly) begin
          rvalid = 1'b1; rdata = get_word(int'(last_araddr >> 3)); rresp = resp_cfg;
          if (rready) r_pend = 0;
        end else begin
          rvalid = 1'b0;
          if (r_pend) r_wait++;
        end
        if (b_pend && b_wait >= b_dly) begin
          bvalid = 1'b1; bresp = resp_cfg;
          if (bready) b_pend = 0;
        end else begin
          bvalid = 1'b0;
          if (b_pend) b_wait++;
        end
        if (arvalid && ar_wait >= ar_dly) begin
          arready = 1'b1; ar_cnt++; last_araddr = araddr; r_pend = 1; r_wait = 0; ar_wait = 0;
        end else begin
          arready = 1'b0;
          if (arvalid) ar_wait++; else ar_wait = 0;
        end
        if (awvalid && aw_wait >= aw_dly) begin
          awready = 1'b1; aw_cnt++; last_awaddr = awaddr; aw_got = 1; aw_wait = 0;
        end else begin
          awready = 1'b0;
          if (awvalid) aw_wait++; else aw_wait = 0;
        end
        if (wvalid && w_wait >= w_dly) begin
          wready = 1'b1; w_cnt++; last_wdata = wdata; last_wstrb = wstrb; w_got = 1; w_wait = 0;
        end else begin
          wready = 1'b0;
          if (wvalid) w_wait++; else w_wait = 0;
        end
        if (aw_got && w_got) begin
          logic [63:0] w;
          w = get_word(int'(last_awaddr >> 3));
          for (int i = 0; i < 8; i++)
            if (last_wstrb[i]) w[i*8 +: 8] = last_wdata[i*8 +: 8];
          word_mem[int'(last_awaddr >> 3)] = w;
          aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
        end
      end
    end
  end

  int obs_last_aw, obs_last_w, obs_first_b;

  // One request; checks latency, single done pulse, addresses/data and model results.
  task automatic run_op(input bit wr, input logic [31:0] a, input logic [7:0] d, input bit dup);
    int cyc, ar0, aw0, w0, exp_lat;
    bit seen;
    ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
    exp_lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
    @(negedge aclk);
    start = 1'b1; write = wr; addr = a; data_write = d;
    @(posedge aclk); #1;
    start = 1'b0;
    check_eq("busy_rise", busy, 1'b1);
    check_eq("first_valid", wr ? (awvalid & wvalid) : arvalid, 1'b1);
    cyc = 1; seen = 0; obs_last_aw = 0; obs_last_w = 0; obs_first_b = 0;
    while (!seen && cyc < 200) begin
      if (awvalid) obs_last_aw = cyc;
      if (wvalid) obs_last_w = cyc;
      if (bready && obs_first_b == 0) obs_first_b = cyc;
      if (dup && cyc == 2) begin
        start = 1'b1; write = ~wr; addr = a ^ 32'h0000_0100;
      end
      if (dup && cyc == 3) start = 1'b0;
      @(posedge aclk); #1;
      cyc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    check_eq("done_seen", seen, 1'b1);
    check_eq("latency", cyc, exp_lat);
    check_eq("busy_in_done", busy, 1'b0);
    if (wr) begin
      check_eq("aw_count", aw_cnt - aw0, 1);
      check_eq("w_count", w_cnt - w0, 1);
      check_eq("awaddr", last_awaddr, {a[31:3], 3'b000});
      check_eq("wdata", last_wdata, {8{d}});
      check_eq("wstrb", last_wstrb, 8'b0000_0001 << a[2:0]);
      if (obs_first_b != 0)
        check_eq("bready_after_aw_w", obs_first_b,
                 ((obs_last_aw > obs_last_w) ? obs_last_aw : obs_last_w) + 1);
      ref_mem[a] = d;
    end else begin
      check_eq("ar_count", ar_cnt - ar0, 1);
      check_eq("araddr", last_araddr, {a[31:3], 3'b000});
      check_eq("data_read", data_read, model_byte(a));
    end
    @(posedge aclk); #1;
    check_eq("done_pulse", done, 1'b0);
    check_eq("idle_after", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge aclk);
    #1;
    check_eq("rst_ctrl", {busy, done, arvalid, rready, awvalid, wvalid, bready}, 7'd0);
    check_eq("rst_data_read", data_read, 8'd0);
    check_eq("rst_addr", {araddr, awaddr}, 64'd0);
    check_eq("rst_wdata", wdata, 64'd0);
    check_eq("rst_wstrb", wstrb, 8'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    word_mem[int'(32'h0000_1000 >> 3)] = 64'h8877_6655_4433_2211;
    for (int i = 0; i < 8; i++) ref_mem[32'h0000_1000 + i] = 8'(8'h11 * (i + 1));

    run_op(1'b0, 32'h0000_1005, 8'h00, 1'b0);
    check_eq("tp_read_byte", data_read, 8'h66);
    run_op(1'b1, 32'h0000_2003, 8'hA5, 1'b0);
    run_op(1'b0, 32'h0000_2003, 8'h00, 1'b0);
    check_eq("tp_readback", data_read, 8'hA5);

    aw_dly = 4; w_dly = 0;
    run_op(1'b1, 32'h0000_2006, 8'h3C, 1'b0);
    check_eq("aw_hold_cycles", obs_last_aw, 5);
    check_eq("w_hold_cycles", obs_last_w, 1);
    check_eq("bready_first", obs_first_b, 6);
    aw_dly = 0;

    ar_dly = 5;
    run_op(1'b0, 32'h0000_2006, 8'h00, 1'b1);
    ar_dly = 0;

    resp_cfg = 2'b10;
    run_op(1'b0, 32'h0000_1002, 8'h00, 1'b0);
    check_eq("slverr_read", data_read, 8'h33);
    resp_cfg = 2'b00;

    // Reset while waiting in RD_DATA.
    r_dly = 6;
    @(negedge aclk);
    start = 1'b1; write = 1'b0; addr = 32'h0000_1007;
    @(posedge aclk); #1;
    start = 1'b0;
    @(posedge aclk); #1;
    check_eq("pre_rst_rready", rready, 1'b1);
    #2 aresetn = 1'b0;
    #1;
    check_eq("rst_mid_rready", rready, 1'b0);
    check_eq("rst_mid_busy", busy, 1'b0);
    check_eq("rst_mid_done", done, 1'b0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    r_dly = 0;
    repeat (3) @(posedge aclk);
    #1;
    check_eq("no_done_after_rst", done, 1'b0);
    run_op(1'b0, 32'h0000_1007, 8'h00, 1'b0);
    check_eq("post_rst_read", data_read, 8'h88);

    for (int k = 0; k < 40; k++) begin
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); resp_cfg = 2'($urandom_range(0, 3));
      run_op(1'($urandom_range(0, 1)), 32'h0000_3000 + 32'($urandom_range(0, 31)),
             8'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_byte_access.md
# axi_byte_access

Single-byte memory access engine: one 8-bit read or write to a 32-bit byte address, performed as one transaction on a 64-bit AXI4-Lite-style master port. It sits between the channel's data-transfer sequencer and system memory (the DMA path). The sequencer steps addresses and counts; this block handles one byte per `start`.

## Interface
Parameters: none.
- `aclk`  in  1  sole clock; all logic on rising edge.
- `aresetn`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request pulse; sampled only while `busy`=0.
- `write`  in  1  1 = write byte, 0 = read byte; sampled with `start`.
- `addr`  in  32  byte address; sampled with `start`.
- `data_write`  in  8  byte to write; sampled with `start`.
- `busy`  out  1  high while a transaction is in progress.
- `done`  out  1  one-cycle pulse at completion.
- `data_read`  out  8  byte from the last read; held until the next read completes.
- `m_axi_ar*`: `arready` in 1, `araddr` out 32, `arvalid` out 1.
- `m_axi_r*`: `rready` out 1, `rdata` in 64, `rresp` in 2, `rvalid` in 1.
- `m_axi_aw*`: `awready` in 1, `awaddr` out 32, `awvalid` out 1.
- `m_axi_w*`: `wready` in 1, `wdata` out 64, `wstrb` out 8, `wvalid` out 1.
- `m_axi_b*`: `bready` out 1, `bresp` in 2, `bvalid` in 1.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. `busy` = (state != IDLE).
- IDLE + `start`:
  - Latch `addr`, `write` and `data_write`.
  - Go to WR_REQ if `write`=1, otherwise RD_ADDR.
- Addresses: `araddr` and `awaddr` = {addr[31:3], 3'b000}. Lane = addr[2:0].
- RD_ADDR:
  - `arvalid`=1.
  - On `arvalid`&&`arready`: drop `arvalid` and go to RD_DATA.
- RD_DATA:
  - `rready`=1.
  - On `rvalid`&&`rready`: `data_read` <= rdata[8*lane +: 8]; drop `rready`; pulse `done`; go to IDLE.
- WR_REQ:
  - `awvalid`=1 and `wvalid`=1, raised together.
  - `wdata` = `data_write` replicated in all 8 lanes; `wstrb` = 8'b1 << lane.
  - Each valid drops independently on its own handshake.
  - When both handshakes have occurred (same or different cycles), go to WR_RESP.
- WR_RESP:
  - `bready`=1.
  - On `bvalid`&&`bready`: drop `bready`; pulse `done`; go to IDLE.
- `rresp`/`bresp` are ignored. Error responses complete normally; on a read, `data_read` is still updated.
- A `start` while `busy`=1 is ignored and has no effect.
- Exactly one outstanding transaction; no bursts.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `busy`, `done`, `arvalid`, `rready`, `awvalid`, `wvalid`, `bready` = 0; `data_read`, `araddr`, `awaddr`, `wdata`, `wstrb` = 0.
- Reset mid-operation: every valid/ready and `done` clear immediately (asynchronously). The transaction is abandoned and no `done` is issued.
- From `start` sampled at edge N, `busy` and the first valid (`arvalid`, or `awvalid`+`wvalid`) are high from N+1.
- Valids stay asserted and address/data stay stable until their handshake.
- `done` is high the cycle after the final handshake (R or B). `busy` is low in that same cycle, so a new `start` may be presented during the `done` cycle.
- Minimum latency with always-ready slave, `start` to `done`:
  - read: 3 cycles (AR at N+1, R at N+2, `done` at N+3);
  - write: 3 cycles (AW/W at N+1, B at N+2, `done` at N+3).
- `data_read` changes only on the read's R handshake edge, so it is valid when `done` rises.

## Test plan
- Read, addr=0x0000_1005, slave returns rdata=0x8877_6655_4433_2211 -> araddr=0x0000_1000, `data_read`=0x66, one `done` pulse, `busy` 1->0 in the `done` cycle.
- Write, addr=0x0000_2003, data_write=0xA5, slave ready -> awaddr=0x0000_2000, wstrb=0x08, wdata=0xA5A5_A5A5_A5A5_A5A5, `done` 3 cycles after `start`.
- Write with `awready` delayed 4 cycles and `wready` immediate -> `wvalid` drops after 1 cycle, `awvalid` holds 5 cycles, `bready` rises only after the AW handshake, a single `done`.
- `start` pulsed while a read is stalled on `arready`=0 -> second request ignored; exactly one AR transaction; `addr` unchanged.
- Read returning rresp=2'b10 -> `done` still pulses and `data_read` is updated.
- `aresetn` low during RD_DATA -> `rready`, `busy`, `done` = 0 immediately. After release, a new read completes normally.
